// File: rtl/edge_post.sv
// Edge post-processing: saturates the Sobel magnitude, blanks the window warm-up border, tags frame/line position.
// Latency: 1 cycle from input transfer to valid; 1 pixel/cycle sustained.
// Backpressure: single-entry output register; ready_o = !valid_o || ready_i, so a stalled output stalls the input.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   valid_i, ready_o  input handshake; mag_i is the 2*WIDTH_P-bit unsigned magnitude
//   valid_o, ready_i  output handshake; data_o pixel, sof_o/eol_o position tags qualifying data_o
//
// Optional build macro EDGE_POST_THRESH_EN: binarise non-border pixels against THRESH_P
// (full scale when sat >= THRESH_P, else 0). Undefined: non-border pixels pass the saturated value.
module edge_post #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480,
    parameter int BORDER_P  = 2,
    parameter int THRESH_P  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*WIDTH_P-1:0]   mag_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_P-1:0]     data_o,
    output logic                   sof_o,
    output logic                   eol_o
);

    localparam int CW = $clog2(LINE_W_P);
    localparam int RW = $clog2(FRAME_H_P);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H_P - 1);

    // Elaboration-time guards on the legal parameter ranges.
    if (LINE_W_P < 3 || FRAME_H_P < 3) begin : g_bad_dims
        $error("edge_post: LINE_W_P and FRAME_H_P must be >= 3");
    end
    if (BORDER_P < 0 || BORDER_P >= LINE_W_P || BORDER_P >= FRAME_H_P) begin : g_bad_border
        $error("edge_post: BORDER_P out of range");
    end
    if (THRESH_P < 0) begin : g_bad_thresh
        $error("edge_post: THRESH_P must be non-negative");
    end

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               in_xfer;
    logic               col_mask;
    logic               row_mask;
    logic [WIDTH_P-1:0] sat;
    logic [WIDTH_P-1:0] pix_val;

    assign ready_o = !valid_o || ready_i;
    assign in_xfer = valid_i && ready_o;

    // Any set bit in the upper half means the magnitude exceeds full scale.
    assign sat = (|mag_i[2*WIDTH_P-1:WIDTH_P]) ? {WIDTH_P{1'b1}} : mag_i[WIDTH_P-1:0];

    // With no border the compare against zero would be constant; tie it off instead.
    if (BORDER_P == 0) begin : g_nomask
        assign col_mask = 1'b0;
        assign row_mask = 1'b0;
    end else begin : g_mask
        assign col_mask = (col < CW'(BORDER_P));
        assign row_mask = (row < RW'(BORDER_P));
    end

`ifdef EDGE_POST_THRESH_EN
    // Compare at the input width so a threshold above full scale never matches.
    localparam logic [2*WIDTH_P-1:0] THR = (2*WIDTH_P)'(THRESH_P);
    assign pix_val = ({{WIDTH_P{1'b0}}, sat} >= THR) ? {WIDTH_P{1'b1}} : {WIDTH_P{1'b0}};
`else
    assign pix_val = sat;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sof_o   <= 1'b0;
            eol_o   <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            if (in_xfer) begin
                // A new sample overwrites the register even if the old one leaves this cycle.
                valid_o <= 1'b1;
                data_o  <= (col_mask || row_mask) ? '0 : pix_val;
                sof_o   <= (row == '0) && (col == '0);
                eol_o   <= (col == COL_LAST);
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/edge_post.md
Name: edge_post

Overview:
Post-processing stage directly downstream of the Sobel magnitude stage, and upstream of the 24-bit RGB replication/pipe.
- Saturates the 2*WIDTH_P magnitude to WIDTH_P bits.
- Blanks the invalid border pixels produced by the 3x3 window warm-up (first 2 rows, first 2 columns of each frame).
- Tracks pixel position with column/row counters and tags start-of-frame and end-of-line.
- Output is a registered valid/ready stage.

Parameters:
WIDTH_P, 8, output pixel width; input magnitude is 2*WIDTH_P.
LINE_W_P, 640, pixels per line; legal range >= 3.
FRAME_H_P, 480, lines per frame; legal range >= 3.
BORDER_P, 2, leading rows and columns forced to zero; legal range 0 to min(LINE_W_P, FRAME_H_P)-1.
THRESH_P, 64, binarisation threshold; used only with the optional feature.

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  magnitude sample valid
ready_o  output  1  stage can accept a sample
mag_i  input  2*WIDTH_P  unsigned magnitude from the magnitude stage
valid_o  output  1  output pixel valid
ready_i  input  1  downstream ready
data_o  output  WIDTH_P  processed pixel
sof_o  output  1  qualifies data_o: first pixel of frame (row 0, col 0)
eol_o  output  1  qualifies data_o: last pixel of a line (col LINE_W_P-1)

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset values: valid_o=0, data_o=0, sof_o=0, eol_o=0, col=0, row=0. ready_o=1 from the first cycle after reset.
- Handshake: an input transfer occurs when valid_i && ready_o. An output transfer occurs when valid_o && ready_i.
  - ready_o = !valid_o || ready_i (combinational; single-entry pipe register, no bubble under continuous flow).
  - While valid_o=1 and ready_i=0: data_o, sof_o and eol_o hold stable and valid_o stays high.
- Latency: exactly 1 cycle from input transfer to valid_o; full throughput of 1 pixel/cycle.
- Saturation: sat = (mag_i > 2^WIDTH_P - 1) ? 2^WIDTH_P - 1 : mag_i[WIDTH_P-1:0]. Example: mag 300 gives 255; mag 255 gives 255.
- Border mask: if col < BORDER_P or row < BORDER_P, the registered data is 0; otherwise it is sat (or the thresholded value when the optional feature is enabled).
- Counters advance only on an input transfer.
  - col increments. At col == LINE_W_P-1, col wraps to 0 and row increments.
  - At row == FRAME_H_P-1 and col == LINE_W_P-1, both counters wrap to 0 (next frame).
- Tags are registered alongside data:
  - sof = (row==0 && col==0) at the time of the input transfer.
  - eol = (col == LINE_W_P-1) at the time of the input transfer.
- Simultaneous input and output transfer in the same cycle: the register loads the new sample. valid_o stays 1.
- Reset mid-frame: any held output is dropped and the counters return to 0. The next accepted pixel is treated as row 0, col 0 with sof=1.
- Input that arrives while valid_i=0 is not counted. No timeout. Upstream stalls are invisible apart from valid_o deasserting.
- Counter widths: $clog2(LINE_W_P) and $clog2(FRAME_H_P). No arithmetic overflow is permitted at the wrap points.

Optional Feature:
Macro: EDGE_POST_THRESH_EN.
- Defined: a non-masked pixel outputs 2^WIDTH_P - 1 when sat >= THRESH_P, else 0. Masked border pixels remain 0. Latency is unchanged (compare happens in the same cycle as saturation).
- Undefined: non-masked pixels output sat directly. THRESH_P is ignored, and no comparator is synthesised.

Test Plan:
1. Saturation (LINE_W_P=4, FRAME_H_P=3, BORDER_P=0, ready_i=1): send mag 0, 100, 255, 300 -> data_o 0, 100, 255, 255, each 1 cycle after the input transfer.
2. Border mask (LINE_W_P=4, FRAME_H_P=3, BORDER_P=2): stream 12 samples of mag 50 -> only row 2, cols 2-3 output 50; the other 10 output 0. sof_o high on output 0, eol_o high on outputs 3, 7, 11.
3. Frame wrap: continue with a 13th sample of mag 50 in the test 2 configuration -> sof_o=1 and data_o=0 (row 0, col 0 masked).
4. Backpressure: hold ready_i=0 for 5 cycles with valid_i=1 -> ready_o=0 after the first accept, data_o/sof_o/eol_o stable, no sample lost or duplicated. Release -> the output sequence matches the no-stall reference exactly.
5. Reset mid-frame: assert rst_i for 1 cycle after 6 of 12 samples -> valid_o=0 the next cycle. The following sample emerges with sof_o=1, col and row reset to 0.
6. With EDGE_POST_THRESH_EN and THRESH_P=64, BORDER_P=0: send mag 63, 64, 1000 -> data_o 0, 255, 255.
